// File: rtl/weight_fetcher.sv
// ---------------------------------------------------------------------------
// WeightFetcher: streams a contiguous block of weight words from a
// single-cycle-latency weight memory into a small output FIFO and presents
// them on a valid/ready stream, marking the final word of the block.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle request to fetch a block (only honoured when idle)
//   base_addr  : first word address, sampled on an accepted start
//   count      : number of words, sampled on an accepted start
//   busy       : high from an accepted start until the done pulse
//   done       : one-cycle completion pulse
//   err        : range error for the most recent accepted request
//   mem_rd_en  : read strobe to the weight memory
//   mem_addr   : read address to the weight memory
//   mem_rdata  : read data, valid exactly one cycle after mem_rd_en
//   w_valid    : output word valid (FIFO non-empty)
//   w_ready    : downstream accepts the current word
//   w_data     : output weight word (FIFO head)
//   w_last     : w_data is the final word of the block
// ---------------------------------------------------------------------------
module weight_fetcher #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 3048,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [CNT_W:0]      DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] lastAddr_q, lastAddr_d;
  logic                  inflight_q;
  logic                  inflightLast_q;

  logic [DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];
  logic                  fifoLast_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrIdx_q, wrIdx_d;
  logic [PTR_W-1:0]      rdIdx_q, rdIdx_d;
  logic [CNT_W-1:0]      fifoCount_q, fifoCount_d;

  logic                  startAccept;
  logic                  zeroCount;
  logic                  rangeErr;
  logic [ADDR_WIDTH:0]   blockEnd;
  logic [CNT_W:0]        occupancy;
  logic                  issue;
  logic                  lastIssue;
  logic                  push;
  logic                  pop;

  // Request decode and read-issue decision. The range check is done one bit
  // wider than the address so base_addr+count can never wrap. A read is only
  // issued when the FIFO is guaranteed to have room for it, counting the word
  // still in flight from the memory, so the FIFO can never overflow.
  always_comb begin
    startAccept = (state_q == IDLE) && start;
    zeroCount   = (count == '0);
    blockEnd    = {1'b0, base_addr} + {1'b0, count};
    rangeErr    = (blockEnd > MEM_LIMIT);
    occupancy   = {1'b0, fifoCount_q} + {{CNT_W{1'b0}}, inflight_q};
    issue       = (state_q == FETCH) && (remaining_q != '0) && (occupancy < DEPTH_C);
    lastIssue   = issue && (remaining_q == ADDR_WIDTH'(1));
    push        = inflight_q;
    pop         = w_valid && w_ready;
  end

  // Next-state for the read pointer, remaining count and FIFO bookkeeping.
  // lastAddr tracks the most recently issued address so mem_addr can hold it
  // while no read is being issued.
  always_comb begin
    rdPtr_d     = rdPtr_q;
    remaining_d = remaining_q;
    lastAddr_d  = lastAddr_q;
    if (startAccept) begin
      rdPtr_d     = base_addr;
      remaining_d = count;
    end else if (issue) begin
      rdPtr_d     = rdPtr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - ADDR_WIDTH'(1);
      lastAddr_d  = rdPtr_q;
    end

    wrIdx_d = push ? (wrIdx_q + PTR_W'(1)) : wrIdx_q;
    rdIdx_d = pop  ? (rdIdx_q + PTR_W'(1)) : rdIdx_q;

    fifoCount_d = fifoCount_q;
    case ({push, pop})
      2'b10:   fifoCount_d = fifoCount_q + CNT_W'(1);
      2'b01:   fifoCount_d = fifoCount_q - CNT_W'(1);
      default: fifoCount_d = fifoCount_q;
    endcase
  end

  // Control FSM with registered busy/done/err. Empty or out-of-range
  // requests skip straight to FINISH without touching the memory. The block
  // ends when the word tagged as last is handed off downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAccept) begin
            err_q <= rangeErr && !zeroCount;
            if (zeroCount || rangeErr) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (lastIssue) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && w_last) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Datapath registers. The in-flight flag marks that mem_rdata carries a
  // word this cycle; it is cleared by reset so a stale return right after
  // reset release is dropped. The last tag travels with each word through
  // the FIFO so w_last stays aligned with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q        <= '0;
      remaining_q    <= '0;
      lastAddr_q     <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      wrIdx_q        <= '0;
      rdIdx_q        <= '0;
      fifoCount_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoData_q[i] <= '0;
        fifoLast_q[i] <= 1'b0;
      end
    end else begin
      rdPtr_q        <= rdPtr_d;
      remaining_q    <= remaining_d;
      lastAddr_q     <= lastAddr_d;
      inflight_q     <= issue;
      inflightLast_q <= lastIssue;
      wrIdx_q        <= wrIdx_d;
      rdIdx_q        <= rdIdx_d;
      fifoCount_q    <= fifoCount_d;
      if (push) begin
        fifoData_q[wrIdx_q] <= mem_rdata;
        fifoLast_q[wrIdx_q] <= inflightLast_q;
      end
    end
  end

  // Output mapping: the FIFO head drives the stream directly, so data and
  // last are stable for as long as the head is not consumed.
  always_comb begin
    busy      = busy_q;
    done      = done_q;
    err       = err_q;
    mem_rd_en = issue;
    mem_addr  = issue ? rdPtr_q : lastAddr_q;
    w_valid   = (fifoCount_q != '0);
    w_data    = fifoData_q[rdIdx_q];
    w_last    = w_valid && fifoLast_q[rdIdx_q];
  end

endmodule

// File: tb/tb_weight_fetcher.sv
// ---------------------------------------------------------------------------
// Self-checking bench for weight_fetcher. A behavioural memory model returns
// data one cycle after each read strobe (and random junk otherwise). The
// reference model turns each request into the list of addresses and words
// that must appear, in order, and monitors compare the DUT against it.
// ---------------------------------------------------------------------------
module tb_weight_fetcher;

  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int MEMSZ = 3048;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic          w_last;

  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;

  logic [DW-1:0] memModel [MEMSZ];
  logic [DW-1:0] expDataQ [$];
  logic [AW-1:0] expAddrQ [$];
  logic          expErr = 1'b0;

  int cycleCount = 0;
  int readCount = 0;
  int hsCount = 0;
  int firstReadCycle = 0;
  int lastReadCycle = 0;
  int firstHsCycle = 0;
  int lastHsCycle = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;

  weight_fetcher #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (MEMSZ),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_last   (w_last)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency and back-to-back checks.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Weight memory model: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en && int'(mem_addr) < MEMSZ) mem_rdata <= memModel[int'(mem_addr)];
    else mem_rdata <= DW'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Stream and read monitor: every read and every handshake must match the
  // head of the reference lists; stalled words must not change.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin
        readCount++;
        if (readCount == 1) firstReadCycle = cycleCount;
        lastReadCycle = cycleCount;
        if (expAddrQ.size() > 0) begin
          checkOutput("rdAddr", 32'(mem_addr), 32'(expAddrQ[0]));
          void'(expAddrQ.pop_front());
        end else begin
          checkOutput("rdUnexpected", 32'(mem_rd_en), 32'(0));
        end
      end
      if (prevStall) begin
        checkOutput("stallValid", 32'(w_valid), 32'(1));
        checkOutput("stallData", 32'(w_data), 32'(prevData));
        checkOutput("stallLast", 32'(w_last), 32'(prevLast));
      end
      if (!w_valid) checkOutput("lastNoValid", 32'(w_last), 32'(0));
      if (w_valid && w_ready) begin
        hsCount++;
        if (hsCount == 1) firstHsCycle = cycleCount;
        lastHsCycle = cycleCount;
        if (expDataQ.size() > 0) begin
          checkOutput("wData", 32'(w_data), 32'(expDataQ[0]));
          checkOutput("wLast", 32'(w_last), 32'(expDataQ.size() == 1));
          void'(expDataQ.pop_front());
        end else begin
          checkOutput("wordUnexpected", 32'(w_valid), 32'(0));
        end
      end
      prevStall = w_valid && !w_ready;
      prevData  = w_data;
      prevLast  = w_last;
    end else begin
      prevStall = 1'b0;
    end
  end

  // Issues one start pulse (DUT must be idle) and loads the reference lists.
  // Returns at #1 after the accepting edge.
  task automatic applyStimulus(input int b, input int c);
    @(posedge clk);
    #1;
    base_addr = AW'(b);
    count     = AW'(c);
    start     = 1'b1;
    readCount = 0;
    hsCount   = 0;
    expErr    = (c != 0) && ((b + c) > MEMSZ);
    if (!expErr) begin
      for (int i = 0; i < c; i++) begin
        expAddrQ.push_back(AW'(b + i));
        expDataQ.push_back(memModel[b + i]);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs until done with w_ready held high (mode 0) or random (mode 1);
  // optionally pulses a bogus start while busy. Checks the completion state.
  task automatic runUntilDone(input int readyMode, input int budget,
                              input int pulseAt, output int cycles);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < budget) begin
      w_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (n == pulseAt) begin
        start     = 1'b1;
        base_addr = AW'($urandom_range(0, 3000));
        count     = AW'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    cycles = n;
    checkOutput("doneSeen", 32'(seen), 32'(1));
    if (seen) begin
      checkOutput("doneBusy", 32'(busy), 32'(0));
      checkOutput("doneErr", 32'(err), 32'(expErr));
      checkOutput("pendingWords", 32'(expDataQ.size()), 32'(0));
      checkOutput("pendingReads", 32'(expAddrQ.size()), 32'(0));
      if (hsCount > 0) checkOutput("doneAfterLast", 32'(cycleCount), 32'(lastHsCycle + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("donePulse", 32'(done), 32'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int acceptCycle;
    bit reached;
    for (int i = 0; i < MEMSZ; i++) memModel[i] = DW'($urandom);

    // Reset state
    #12;
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstErr", 32'(err), 32'(0));
    checkOutput("rstRdEn", 32'(mem_rd_en), 32'(0));
    checkOutput("rstAddr", 32'(mem_addr), 32'(0));
    checkOutput("rstValid", 32'(w_valid), 32'(0));
    checkOutput("rstData", 32'(w_data), 32'(0));
    checkOutput("rstLast", 32'(w_last), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // base 10, count 5, full throughput
    w_ready = 1'b1;
    applyStimulus(10, 5);
    acceptCycle = cycleCount;
    checkOutput("busyAfterStart", 32'(busy), 32'(1));
    runUntilDone(0, 100, -1, cyc);
    checkOutput("reads5", 32'(readCount), 32'(5));
    checkOutput("firstReadLatency", 32'(firstReadCycle), 32'(acceptCycle));
    checkOutput("readsBackToBack", 32'(lastReadCycle - firstReadCycle), 32'(4));
    checkOutput("wordsBackToBack", 32'(lastHsCycle - firstHsCycle), 32'(4));
    checkOutput("addrHold", 32'(mem_addr), 32'(14));

    // base 0, count 8, downstream stalled for 20 cycles
    w_ready = 1'b0;
    applyStimulus(0, 8);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("stallReads", 32'(readCount), 32'(4));
    checkOutput("stallHeadValid", 32'(w_valid), 32'(1));
    checkOutput("stallHeadData", 32'(w_data), 32'(memModel[0]));
    @(posedge clk);
    #1;
    runUntilDone(0, 100, -1, cyc);
    checkOutput("words8", 32'(hsCount), 32'(8));

    // count 0: immediate done, no traffic
    applyStimulus(5, 0);
    runUntilDone(0, 20, -1, cyc);
    checkOutput("zeroLatency", 32'(cyc), 32'(0));
    checkOutput("zeroReads", 32'(readCount), 32'(0));
    checkOutput("zeroWords", 32'(hsCount), 32'(0));

    // out of range: 3040 + 9 > 3048
    applyStimulus(3040, 9);
    runUntilDone(0, 20, -1, cyc);
    checkOutput("rangeReads", 32'(readCount), 32'(0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("errHold", 32'(err), 32'(1));

    // single word at the top of memory; err clears on the new start
    applyStimulus(3047, 1);
    checkOutput("errClearedOnStart", 32'(err), 32'(0));
    runUntilDone(1, 200, -1, cyc);
    checkOutput("reads1", 32'(readCount), 32'(1));

    // exactly reaching the end of memory is legal; a huge pair must not wrap
    applyStimulus(3040, 8);
    runUntilDone(1, 300, -1, cyc);
    applyStimulus(32'hFFFFF, 32'hFFFFF);
    runUntilDone(0, 20, -1, cyc);
    checkOutput("wrapReads", 32'(readCount), 32'(0));

    // count 100 with random ready and a start pulse while busy
    applyStimulus(100, 100);
    runUntilDone(1, 3000, 7, cyc);
    checkOutput("reads100", 32'(readCount), 32'(100));
    checkOutput("words100", 32'(hsCount), 32'(100));

    // random requests
    for (int k = 0; k < 6; k++) begin
      int c = $urandom_range(1, 40);
      int b = $urandom_range(0, MEMSZ - c);
      applyStimulus(b, c);
      runUntilDone(1, 2000, -1, cyc);
      checkOutput("randWords", 32'(hsCount), 32'(c));
    end

    // reset in the middle of a block
    w_ready = 1'b1;
    applyStimulus(200, 10);
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      @(negedge clk);
      #1;
      if (hsCount >= 3) reached = 1'b1;
    end
    checkOutput("threeWords", 32'(reached), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    expAddrQ.delete();
    expDataQ.delete();
    checkOutput("midRstBusy", 32'(busy), 32'(0));
    checkOutput("midRstDone", 32'(done), 32'(0));
    checkOutput("midRstErr", 32'(err), 32'(0));
    checkOutput("midRstRdEn", 32'(mem_rd_en), 32'(0));
    checkOutput("midRstAddr", 32'(mem_addr), 32'(0));
    checkOutput("midRstValid", 32'(w_valid), 32'(0));
    checkOutput("midRstData", 32'(w_data), 32'(0));
    checkOutput("midRstLast", 32'(w_last), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(500, 6);
    runUntilDone(1, 500, -1, cyc);
    checkOutput("postRstReads", 32'(readCount), 32'(6));
    checkOutput("postRstWords", 32'(hsCount), 32'(6));

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
